nios2_vjtag_scan_host: RTL and testbench

//  Host end of the Nios II debug-slave virtual-JTAG link. Turns one command (IR code + DR word) into a full

---
 rtl/nios2_vjtag_pkg.sv | 14 +
 rtl/nios2_vjtag_tck_gen.sv | 35 +++
 rtl/nios2_vjtag_scan_host.sv | 103 ++++++++++
 tb/tb_nios2_vjtag_scan_host.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/nios2_vjtag_pkg.sv
// nios2_vjtag_pkg: shared state encoding, IR codes and default widths for the
// Nios II virtual-JTAG scan host.
package nios2_vjtag_pkg;
    localparam int DR_WIDTH_DEF = 38;
    localparam int IR_WIDTH_DEF = 2;
    localparam logic [1:0] IR_OCIMEM    = 2'b00;
    localparam logic [1:0] IR_TRACEMEM  = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;
    // Scan states are contiguous so UIR..RTI advance by increment.
    typedef enum logic [2:0] {
        ST_IDLE, ST_UIR, ST_CDR, ST_SDR, ST_UDR, ST_RTI, ST_RSP
    } state_e;
endpackage

// File: rtl/nios2_vjtag_tck_gen.sv
// nios2_vjtag_tck_gen: tck period counter; low for TCK_DIV clk, high for TCK_DIV clk,
// restarting from the low phase whenever run is deasserted.
module nios2_vjtag_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tck,
    output logic rise_tick,
    output logic period_end_tick
);
    localparam int CW = $clog2(2 * TCK_DIV);
    localparam logic [CW-1:0] LAST = CW'(2 * TCK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(TCK_DIV);
    localparam logic [CW-1:0] PRE_RISE = CW'(TCK_DIV - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic tck_q, tck_d;
    always_comb begin
        cnt_d = (!run || cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        tck_d = run && cnt_d >= HALF;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end
    assign tck             = tck_q;
    assign rise_tick       = run && cnt_q == PRE_RISE;
    assign period_end_tick = run && cnt_q == LAST;
endmodule

// File: rtl/nios2_vjtag_scan_host.sv
// nios2_vjtag_scan_host: drives one UIR/CDR/SDR/UDR/RTI scan per command onto the
// vji_* debug-slave interface and returns the DR bits captured from vji_tdo.
module nios2_vjtag_scan_host
    import nios2_vjtag_pkg::*;
#(
    parameter int DR_WIDTH = DR_WIDTH_DEF,
    parameter int IR_WIDTH = IR_WIDTH_DEF,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic                busy,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);
    localparam int BW = $clog2(DR_WIDTH + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);
    state_e state_q, state_d;
    logic [DR_WIDTH-1:0] sr_q, sr_d, rsp_dr_q, rsp_dr_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [4:0] strobe_q, strobe_d;
    logic tdo_q, tdo_d, tdi_q, tdi_d, ready_q, busy_q, rsp_valid_q;
    logic run, rise, pend, accept, shift;

    nios2_vjtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
        .clk             (clk),
        .reset_n         (reset_n),
        .run             (run),
        .tck             (vji_tck),
        .rise_tick       (rise),
        .period_end_tick (pend)
    );

    assign run = state_q != ST_IDLE && state_q != ST_RSP;

    always_comb begin
        accept   = cmd_valid && ready_q;
        shift    = pend && state_q == ST_SDR;
        state_d  = state_q == ST_IDLE ? (accept ? ST_UIR : ST_IDLE) :
                   state_q == ST_RSP  ? ST_IDLE :
                   !pend              ? state_q :
                   (shift && bit_q != BIT_LAST) ? ST_SDR : state_e'(state_q + 3'd1);
        sr_d     = accept ? cmd_dr : shift ? {tdo_q, sr_q[DR_WIDTH-1:1]} : sr_q;
        bit_d    = accept ? '0 : shift ? bit_q + BW'(1) : bit_q;
        tdo_d    = rise ? vji_tdo : tdo_q;
        ir_d     = accept ? cmd_ir : ir_q;
        tdi_d    = state_d == ST_SDR && sr_d[0];
        strobe_d = {state_d == ST_UIR, state_d == ST_CDR, state_d == ST_SDR,
                    state_d == ST_UDR, state_d == ST_RTI};
        // sr is frozen once SDR ends, so RSP can take it directly.
        rsp_dr_d = state_d == ST_RSP ? sr_q : rsp_dr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            bit_q       <= '0;
            tdo_q       <= 1'b0;
            ir_q        <= '0;
            tdi_q       <= 1'b0;
            strobe_q    <= '0;
            rsp_dr_q    <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_q       <= bit_d;
            tdo_q       <= tdo_d;
            ir_q        <= ir_d;
            tdi_q       <= tdi_d;
            strobe_q    <= strobe_d;
            rsp_dr_q    <= rsp_dr_d;
            ready_q     <= state_d == ST_IDLE;
            busy_q      <= state_d != ST_IDLE;
            rsp_valid_q <= state_d == ST_RSP;
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dr    = rsp_dr_q;
    assign vji_tdi   = tdi_q;
    assign vji_ir_in = ir_q;
    assign {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} = strobe_q;
endmodule

// File: tb/tb_nios2_vjtag_scan_host.sv
// tb_nios2_vjtag_scan_host: three hosts (TCK_DIV 2, 1, 5) checked every cycle against
// a period-arithmetic model, plus hand-computed literal expectations.
module tb_nios2_vjtag_scan_host;
    import nios2_vjtag_pkg::*;
    localparam int W = 38;
    logic clk = 1'b0;
    logic reset_n;
    logic cmd_valid [3], cmd_ready [3], rsp_valid [3], busy [3], tck [3], tdi [3], tdo [3];
    logic uir [3], cdr [3], sdr [3], udr [3], rti [3];
    logic [1:0] cmd_ir [3], ir_in [3];
    logic [W-1:0] cmd_dr [3], rsp_dr [3];
    int checks = 0, fails = 0, cyc = 0;
    int mode [3];
    logic act_m [3], rdy_m [3];
    int t_m [3], acc_cyc [3], prev_acc [3], lat_seen [3], rsp_cnt [3];
    logic [W-1:0] cmd_m [3], exp_m [3], last_m [3];
    logic [1:0] ir_m [3];
    int d_c, n_c, p_c, ph_c, k_c, base;
    logic run_c, sd_c;
    logic [11:0] e_c, a_c;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dv(input int g);
        return g == 0 ? 2 : (g == 1 ? 1 : 5);
    endfunction
    function automatic int nn(input int g);
        return 2 * dv(g) * (W + 4) + 1;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gi
        nios2_vjtag_scan_host #(.TCK_DIV(g == 0 ? 2 : (g == 1 ? 1 : 5))) dut (
            .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
            .cmd_ir(cmd_ir[g]), .cmd_dr(cmd_dr[g]), .rsp_valid(rsp_valid[g]), .rsp_dr(rsp_dr[g]),
            .busy(busy[g]), .vji_tck(tck[g]), .vji_tdi(tdi[g]), .vji_tdo(tdo[g]),
            .vji_ir_in(ir_in[g]), .vji_uir(uir[g]), .vji_cdr(cdr[g]), .vji_sdr(sdr[g]),
            .vji_udr(udr[g]), .vji_rti(rti[g]));
    end

    // Model: t_m counts clk since accept; RSP is clk nn(g), IDLE follows.
    always @(posedge clk or negedge reset_n) begin
        for (int g = 0; g < 3; g++) begin
            if (!reset_n) begin
                act_m[g] <= 1'b0; rdy_m[g] <= 1'b0; t_m[g] <= 0;
                ir_m[g] <= '0; last_m[g] <= '0; cmd_m[g] <= '0; exp_m[g] <= '0;
            end else if (act_m[g]) begin
                if (t_m[g] == nn(g)) begin
                    act_m[g] <= 1'b0; rdy_m[g] <= 1'b1;
                end else begin
                    t_m[g] <= t_m[g] + 1;
                    if (t_m[g] + 1 == nn(g)) last_m[g] <= exp_m[g];
                end
            end else if (rdy_m[g] && cmd_valid[g]) begin
                act_m[g] <= 1'b1; rdy_m[g] <= 1'b0; t_m[g] <= 1;
                cmd_m[g] <= cmd_dr[g]; ir_m[g] <= cmd_ir[g];
                exp_m[g] <= mode[g] == 1 ? '1 : cmd_dr[g] << 1;
                prev_acc[g] <= acc_cyc[g]; acc_cyc[g] <= cyc;
            end else begin
                rdy_m[g] <= 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic wait_idle(input int g, input int budget);
        int k = 0;
        while (act_m[g] && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (act_m[g]) begin
            fails++;
            $display("FAIL idle_timeout dut%0d: got busy want idle within %0d clk", g, budget);
        end
    endtask

    task automatic issue(input int g, input logic [1:0] ir, input logic [W-1:0] dr, input int m);
        mode[g] = m; cmd_ir[g] = ir; cmd_dr[g] = dr; cmd_valid[g] = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        for (int g = 0; g < 3; g++) begin
            cmd_valid[g] = 1'b0; cmd_ir[g] = '0; cmd_dr[g] = '0; mode[g] = 0;
            lat_seen[g] = 0; rsp_cnt[g] = 0; tdo[g] = 1'b0;
        end
        fork
            forever begin
                @(negedge clk);
                for (int g = 0; g < 3; g++) begin
                    d_c   = dv(g);
                    n_c   = nn(g);
                    p_c   = (t_m[g] - 1) / (2 * d_c);
                    ph_c  = (t_m[g] - 1) % (2 * d_c);
                    run_c = act_m[g] && t_m[g] >= 1 && t_m[g] < n_c;
                    sd_c  = run_c && p_c >= 2 && p_c < W + 2;
                    k_c   = sd_c ? p_c - 2 : 0;
                    // tdo = tdi of the previous SDR period (loopback) or constant 1
                    tdo[g] = mode[g] == 1 ? 1'b1 : (sd_c && k_c > 0 && cmd_m[g][k_c > 0 ? k_c - 1 : 0]);
                    e_c = {rdy_m[g], act_m[g], act_m[g] && t_m[g] == n_c, run_c && ph_c >= d_c,
                           sd_c && cmd_m[g][k_c], run_c && p_c == 0, run_c && p_c == 1, sd_c,
                           run_c && p_c == W + 2, run_c && p_c == W + 3, ir_m[g]};
                    a_c = {cmd_ready[g], busy[g], rsp_valid[g], tck[g], tdi[g], uir[g], cdr[g],
                           sdr[g], udr[g], rti[g], ir_in[g]};
                    checks++;
                    if (a_c !== e_c) begin
                        fails++;
                        $display("FAIL cycle_outputs dut%0d t=%0d: got %b want %b", g, t_m[g], a_c, e_c);
                    end
                    checks++;
                    if (rsp_dr[g] !== last_m[g]) begin
                        fails++;
                        $display("FAIL cycle_rsp_dr dut%0d t=%0d: got %h want %h", g, t_m[g], rsp_dr[g], last_m[g]);
                    end
                    if (rsp_valid[g] === 1'b1) begin
                        lat_seen[g] = t_m[g];
                        rsp_cnt[g]++;
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {cmd_ready[0], busy[0], rsp_valid[0], tck[0], tdi[0], uir[0], cdr[0],
                              sdr[0], udr[0], rti[0], ir_in[0], rsp_dr[0]}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", 64'(cmd_ready[0]), 64'd1);

        for (int g = 0; g < 3; g++) issue(g, IR_BREAK, 38'h2A_5555_AAAA, 0);
        @(posedge clk); #1;
        for (int g = 0; g < 3; g++) cmd_valid[g] = 1'b0;
        for (int g = 0; g < 3; g++) wait_idle(g, 600);
        for (int g = 0; g < 3; g++) chk($sformatf("loopback_rsp_dut%0d", g), 64'(rsp_dr[g]), 64'h14_AAAB_5554);
        chk("latency_div2", 64'(lat_seen[0]), 64'd169);
        chk("latency_div1", 64'(lat_seen[1]), 64'd85);
        chk("latency_div5", 64'(lat_seen[2]), 64'd421);

        issue(0, IR_OCIMEM, '0, 1);
        @(posedge clk); #1;
        cmd_valid[0] = 1'b0;
        wait_idle(0, 600);
        chk("tdo_high_rsp", 64'(rsp_dr[0]), 64'h3F_FFFF_FFFF);

        base = rsp_cnt[0];
        issue(0, IR_BREAK, 38'h01_2345_6789, 0);
        @(posedge clk); #1;
        cmd_ir[0] = IR_TRACECTRL;
        repeat (60) @(posedge clk);
        #1;
        cmd_valid[0] = 1'b0;
        wait_idle(0, 600);
        repeat (4) @(posedge clk);
        #1;
        chk("busy_ignore_ir", 64'(ir_in[0]), 64'(2'b10));
        chk("busy_ignore_rsp_count", 64'(rsp_cnt[0] - base), 64'd1);
        chk("busy_ignore_rsp", 64'(rsp_dr[0]), 64'h02_468A_CF12);

        issue(0, IR_TRACEMEM, 38'h3F_0F0F_0F0F, 0);
        @(posedge clk); #1;
        cmd_ir[0] = IR_TRACECTRL;
        cmd_dr[0] = 38'h15_5555_5555;
        wait_idle(0, 600);
        @(posedge clk); #1;
        cmd_valid[0] = 1'b0;
        chk("b2b_accept_gap", 64'(acc_cyc[0] - prev_acc[0]), 64'd170);
        chk("b2b_second_ir", 64'(ir_in[0]), 64'(2'b11));
        wait_idle(0, 600);
        chk("b2b_second_rsp", 64'(rsp_dr[0]), 64'h2A_AAAA_AAAA);

        base = rsp_cnt[0];
        issue(0, IR_OCIMEM, 38'h2A_5555_AAAA, 0);
        @(posedge clk); #1;
        cmd_valid[0] = 1'b0;
        for (int k = 0; k < 100 && t_m[0] != 50; k++) begin
            @(posedge clk); #1;
        end
        chk("reach_sdr_bit10", 64'(t_m[0]), 64'd50);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_outputs", {cmd_ready[0], busy[0], rsp_valid[0], tck[0], tdi[0], uir[0], cdr[0],
                              sdr[0], udr[0], rti[0], ir_in[0], rsp_dr[0]}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready_tck", {62'd0, cmd_ready[0], tck[0]}, 64'b10);
        repeat (200) @(posedge clk);
        #1;
        chk("abort_no_rsp", 64'(rsp_cnt[0] - base), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
